// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply controller that borrows the shared execute-stage ALU.
// One ALU iteration per RUN cycle; the low WIDTH bits of op_a*op_b are returned on done.
module alu_mul_sequencer #(
    parameter int WIDTH      = 64,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             prod_zero,
    output logic             prod_negative,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_product;
    logic             r_prod_zero;
    logic             r_prod_negative;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_last;

    // The current iteration is the final one: all bits consumed, or no set multiplier bits remain.
    assign w_last = (r_count == CW'(WIDTH - 1)) ||
                    (EARLY_EXIT && (r_mplier[WIDTH-1:1] == {(WIDTH-1){1'b0}}));

    // Controller FSM with the datapath registers and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_acc           <= {WIDTH{1'b0}};
            r_mcand         <= {WIDTH{1'b0}};
            r_mplier        <= {WIDTH{1'b0}};
            r_count         <= {CW{1'b0}};
            r_product       <= {WIDTH{1'b0}};
            r_prod_zero     <= 1'b1;
            r_prod_negative <= 1'b0;
            r_ready         <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_acc    <= {WIDTH{1'b0}};
                        r_count  <= {CW{1'b0}};
                        r_state  <= S_RUN;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Cancelled work never reaches product or the flags.
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_acc    <= alu_result;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        if (w_last) begin
                            r_product       <= alu_result;
                            r_prod_zero     <= (alu_result == {WIDTH{1'b0}});
                            r_prod_negative <= alu_result[WIDTH-1];
                            r_state         <= S_DONE;
                            r_busy          <= 1'b0;
                            r_done          <= 1'b1;
                        end else begin
                            r_count <= r_count + CW'(1);
                            r_state <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // ALU drive: add the shifted multiplicand on a set bit, otherwise pass the accumulator through.
    always_comb begin
        alu_A     = {WIDTH{1'b0}};
        alu_B     = {WIDTH{1'b0}};
        alu_cntrl = 3'b000;
        case (r_state)
            S_RUN: begin
                if (r_mplier[0]) begin
                    alu_A     = r_acc;
                    alu_B     = r_mcand;
                    alu_cntrl = 3'b010;
                end else begin
                    alu_A     = {WIDTH{1'b0}};
                    alu_B     = r_acc;
                    alu_cntrl = 3'b000;
                end
            end
            default: begin
                alu_A     = {WIDTH{1'b0}};
                alu_B     = {WIDTH{1'b0}};
                alu_cntrl = 3'b000;
            end
        endcase
    end

    assign ready         = r_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign product       = r_product;
    assign prod_zero     = r_prod_zero;
    assign prod_negative = r_prod_negative;

endmodule
